// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit
package fetch_pkg;

    localparam int PC_STEP     = 4;
    localparam int FETCH_DEPTH = 2;
    localparam int PC_W        = 32;
    localparam int INSTR_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry fetch buffer, head always in slot 0, clear wins over push/pop
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t e0, e1;
    logic [1:0]   keep;

    assign keep = count - 2'(pop);
    assign head = e0;

    // occupancy and slot shifting; an incoming word lands in the first free slot after the pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            e0    <= '0;
            e1    <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= keep + 2'(push);
            if (push) begin
                if (keep == 2'd0) e0 <= din;
                else e1 <= din;
            end else if (pop) begin
                e0 <= e1;
            end
        end
    end

endmodule

// File: rtl/imem_fetch.sv
// imem_fetch: single-outstanding instruction fetch with redirect and 2-entry buffer
module imem_fetch
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] fetch_pc, req_pc, tgt, nxt_pc;
    logic [1:0]        count, cnt_nx;
    logic              pend, push, pop, space;
    fetch_entry_t      head;

    // a redirect clears the buffer this edge, so it always leaves room and suppresses push/pop
    assign tgt    = redirect_pc & ~ADDR_W'(3);
    assign push   = (state == WAIT) & mem_rvalid & ~redirect_valid;
    assign pop    = instr_valid & instr_ready & ~redirect_valid;
    assign cnt_nx = redirect_valid ? 2'd0 : count + 2'(push) - 2'(pop);
    assign space  = cnt_nx < 2'(FETCH_DEPTH);
    assign nxt_pc = redirect_valid ? tgt : (state == WAIT) ? req_pc + ADDR_W'(PC_STEP) : fetch_pc;

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect_valid),
        .din   ('{pc: req_pc, instr: mem_rdata}),
        .head  (head),
        .count (count)
    );

    assign instr_valid = count != 2'd0;
    assign instr_data  = head.instr;
    assign instr_pc    = head.pc;

    // request sequencer: issue, hold until grant, await or discard the single response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            pend     <= 1'b0;
        end else begin
            if (redirect_valid) fetch_pc <= tgt;
            case (state)
                IDLE: if (space) begin
                    mem_req  <= 1'b1;
                    mem_addr <= nxt_pc;
                    state    <= REQ;
                end
                REQ: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    req_pc  <= mem_addr;
                    pend    <= 1'b0;
                    state   <= (redirect_valid | pend) ? FLUSH : WAIT;
                end else if (redirect_valid) begin
                    pend <= 1'b1;
                end
                WAIT, FLUSH: if (mem_rvalid) begin
                    fetch_pc <= nxt_pc;
                    if (space) begin
                        mem_req  <= 1'b1;
                        mem_addr <= nxt_pc;
                        state    <= REQ;
                    end else begin
                        state <= IDLE;
                    end
                end else if (redirect_valid) begin
                    state <= FLUSH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: randomized fetch bench with memory model and program-order stream reference
module tb_imem_fetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] SALT   = 32'hA5A5_A5A5;

    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic        redirect_valid = 1'b0, instr_valid, instr_ready = 1'b0;
    logic [31:0] mem_addr, mem_rdata = '0, redirect_pc = '0, instr_data, instr_pc;

    int total = 0, bad = 0;

    logic [31:0] exp_pc, exp_gnt, m_addr, hold_addr;
    bit          stale, m_busy, held, chk_empty;
    int          m_lat, pops;

    imem_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        exp_pc    = RST_PC;
        exp_gnt   = RST_PC;
        stale     = 1'b0;
        m_busy    = 1'b0;
        held      = 1'b0;
        chk_empty = 1'b0;
        m_lat     = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req", 64'(mem_req), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(RST_PC));
        check("rst_valid", 64'(instr_valid), 64'(0));
        check("rst_data", 64'(instr_data), 64'(0));
        check("rst_pc", 64'(instr_pc), 64'(0));
    endtask

    // one clock of stimulus: memory model, decode consumer, redirect source, and reference checks
    task automatic cycle(input int rdy_pct, input int gnt_pct, input int lat_max,
                         input int redir_pct, input bit redir_on_rv, input logic [31:0] ftgt);
        bit          redir;
        logic [31:0] r, tgt;
        @(negedge clk);
        if (chk_empty) check("flush_empty", 64'(instr_valid), 64'(0));
        if (held) check("req_hold", 64'({mem_req, mem_addr}), 64'({1'b1, hold_addr}));
        mem_rvalid  = m_busy && m_lat == 0;
        if (m_busy && m_lat > 0) m_lat--;
        mem_rdata   = mem_rvalid ? (m_addr ^ SALT) : $urandom;
        mem_gnt     = mem_req && (int'($urandom_range(99)) < gnt_pct);
        instr_ready = int'($urandom_range(99)) < rdy_pct;
        redir       = redir_on_rv ? mem_rvalid : (int'($urandom_range(99)) < redir_pct);
        r           = $urandom;
        tgt         = (ftgt != 0) ? ftgt : (r[0] ? {28'hFFFF_FFF, r[7:4]} : r);
        redirect_valid = redir;
        redirect_pc    = tgt;
        if (instr_valid && instr_ready && !redir) begin
            check("pop_pc", 64'(instr_pc), 64'(exp_pc));
            check("pop_data", 64'(instr_data), 64'(exp_pc ^ SALT));
            exp_pc += 4;
            pops++;
        end
        if (mem_gnt) begin
            if (stale) stale = 1'b0;
            else begin
                check("gnt_addr", 64'(mem_addr), 64'(exp_gnt));
                exp_gnt += 4;
            end
        end
        held      = mem_req && !mem_gnt;
        hold_addr = mem_addr;
        if (mem_rvalid) m_busy = 1'b0;
        if (mem_gnt) begin
            m_busy = 1'b1;
            m_addr = mem_addr;
            m_lat  = $urandom_range(lat_max, 0);
        end
        if (redir) begin
            exp_pc  = tgt & 32'hFFFF_FFFC;
            exp_gnt = tgt & 32'hFFFF_FFFC;
            stale   = mem_req && !mem_gnt;
        end
        chk_empty = redir;
    endtask

    initial begin
        model_reset();
        pops = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        check("req_rise", 64'({mem_req, mem_addr}), 64'({1'b1, RST_PC}));

        // back-to-back fetch across the address wrap
        repeat (4) cycle(100, 100, 0, 0, 0, 0);
        pops = 0;
        repeat (20) cycle(100, 100, 0, 0, 0, 0);
        check("throughput", 64'(pops), 64'(10));

        // decode stalled: buffer fills to two and fetching stops
        repeat (12) cycle(0, 100, 0, 0, 0, 0);
        check("full_req", 64'(mem_req), 64'(0));
        check("full_valid", 64'(instr_valid), 64'(1));
        check("full_head", 64'(instr_pc), 64'(exp_pc));
        repeat (10) cycle(100, 100, 0, 0, 0, 0);

        // grant withheld for three cycles while the request is pending
        for (int i = 0; i < 20 && !mem_req; i++) cycle(100, 0, 0, 0, 0, 0);
        check("wait_req", 64'(mem_req), 64'(1));
        repeat (3) cycle(100, 0, 0, 0, 0, 0);
        repeat (6) cycle(100, 100, 0, 0, 0, 0);

        // redirect while a response is outstanding
        for (int i = 0; i < 50 && !(m_busy && m_lat > 0); i++) cycle(100, 100, 3, 0, 0, 0);
        check("wait_busy", 64'(m_busy && m_lat > 0), 64'(1));
        cycle(100, 100, 3, 100, 0, 32'h0000_0103);
        for (int i = 0; i < 40 && !instr_valid; i++) cycle(0, 100, 3, 0, 0, 0);
        check("redir_head", 64'({instr_valid, instr_pc}), 64'({1'b1, 32'h0000_0100}));
        repeat (8) cycle(100, 100, 0, 0, 0, 0);

        // redirect coinciding with a response and a ready consumer
        repeat (12) cycle(100, 100, 0, 100, 1, 32'h0000_0200);
        repeat (8) cycle(100, 100, 0, 0, 0, 0);

        // long random mix
        repeat (3000) cycle(70, 60, 3, 4, 0, 0);

        // reset while waiting on a response
        for (int i = 0; i < 50 && !(m_busy && !mem_req); i++) cycle(100, 100, 3, 0, 0, 0);
        check("wait_inflight", 64'(m_busy && !mem_req), 64'(1));
        rst = 1'b1;
        #1;
        check_reset_outputs();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("req_rise2", 64'({mem_req, mem_addr}), 64'({1'b1, RST_PC}));
        pops = 0;
        repeat (20) cycle(100, 100, 0, 0, 0, 0);
        check("post_rst_pops", 64'(pops >= 8), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Instruction-memory initiator for the RISC-V core: drives word-aligned fetch addresses into the instruction SRAM through a request/grant/response handshake, captures returned words into a 2-entry fetch buffer, and presents them, tagged with their PC, to decode over a valid/ready interface. It accepts branch/jump redirects from execute and discards any in-flight or buffered wrong-path words.

## Interface
- `ADDR_W`, 32, fetch address / PC width.
- `DATA_W`, 32, instruction word width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_req`  out  1  fetch request; held until `mem_gnt`.
- `mem_addr`  out  ADDR_W  word-aligned fetch address, stable while `mem_req`=1.
- `mem_gnt`  in  1  memory accepts request this cycle.
- `mem_rvalid`  in  1  read data valid; one response per grant, in order.
- `mem_rdata`  in  DATA_W  read data.
- `redirect_valid`  in  1  single-cycle pulse: new fetch PC.
- `redirect_pc`  in  ADDR_W  redirect target; bits [1:0] ignored, forced to 0.
- `instr_valid`  out  1  buffer head valid.
- `instr_data`  out  DATA_W  instruction at head.
- `instr_pc`  out  ADDR_W  PC of head instruction.
- `instr_ready`  in  1  decode consumes head when `instr_valid` & `instr_ready`.

## Operation
- States: IDLE, REQ, WAIT, FLUSH. At most one outstanding request.
- `fetch_pc`: next address to request; `req_pc`: address of outstanding request.
- Space check: `count_next` = count + push − pop; request issued only if `count_next` < 2.
- IDLE: if space, `mem_req`←1, `mem_addr`←`fetch_pc`, → REQ.
- REQ: `mem_req` held, `mem_addr` unchanged until `mem_gnt`. On gnt: `mem_req`←0, `req_pc`←`mem_addr`, → WAIT (→ FLUSH if redirect this cycle or pending).
- WAIT: on `mem_rvalid`: push {`req_pc`, `mem_rdata`}, `fetch_pc`←`req_pc`+4; if space after push, issue next request directly (→ REQ), else → IDLE.
- FLUSH: on `mem_rvalid`: data dropped, no push; → REQ with `fetch_pc` (redirect target) if space, else IDLE.
- Redirect (any state): buffer cleared same edge (count←0), `fetch_pc`←{`redirect_pc`[ADDR_W-1:2],2'b00}. IDLE → REQ with target next edge. REQ: request completes unchanged, response discarded (pending flag → FLUSH at gnt). WAIT → FLUSH; if `mem_rvalid` same cycle, response dropped and → REQ with target.
- Redirect + `instr_ready` same cycle: pop ignored, buffer cleared.
- Redirect while FLUSH: target updated, still one response to drop.
- PC arithmetic modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 → 32'h0000_0000.
- Push and pop same cycle with count=2 impossible (space rule); with count=1 count stays 1.
- Reset mid-transaction: all state cleared; a late `mem_rvalid` after reset while IDLE/REQ is ignored (memory must be reset together with this block).

## Timing
- Reset values: `mem_req`=0, `mem_addr`=`RESET_PC`, `instr_valid`=0, `instr_data`=0, `instr_pc`=0, state IDLE, count 0, `fetch_pc`=`RESET_PC`.
- `mem_req` rises on first rising edge with `rst` low.
- All outputs registered or decoded from registers; no combinational input→output path.
- `mem_rvalid` earliest one cycle after `mem_gnt`; `mem_gnt` may coincide with first `mem_req` cycle.
- Response → `instr_valid`: 1 edge (visible cycle after `mem_rvalid`).
- Peak throughput: one word per 2 cycles (gnt immediate, rvalid next cycle).
- Redirect at edge N → `mem_addr`=target visible cycle N+1 when IDLE, or edge after discarded response when WAIT/FLUSH.

## Structure
- Package `fetch_pkg`: `fetch_state_e` (IDLE/REQ/WAIT/FLUSH), `fetch_entry_t` struct {pc, instr}, `PC_STEP`=4, `FETCH_DEPTH`=2.
- Sub-module `fetch_fifo`: 2-entry FIFO of `fetch_entry_t` with push/pop/clear, count output; clear has priority over push/pop.

## Test plan
- Reset release, memory gnt immediate, rvalid +1, rdata=addr^32'hA5A5_A5A5, ready=1 → PCs 0,4,8,… in order, one instr every 2 cycles, data matches.
- `instr_ready`=0 for 10 cycles → exactly 2 entries buffered, `mem_req` low after second response; ready=1 → drains 0,4 then fetch resumes at 8.
- `mem_gnt` delayed 3 cycles → `mem_req` and `mem_addr` stable throughout, single response accepted.
- Redirect to 32'h0000_0103 during WAIT → outstanding word dropped, buffer empty, next `mem_addr`=32'h0000_0100, first `instr_pc`=32'h100.
- Redirect same cycle as `mem_rvalid` and `instr_ready` → no push, no pop effect, count 0, next request at target.
- `RESET_PC`=32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; then assert `rst` mid-WAIT → all outputs at reset values immediately.
